// File: rtl/apb_master_multi_bridge.sv
// Purpose   : APB4 master bridge; queued user commands become SETUP/ACCESS transfers to one of NUM_SLAVES slaves.
// Latency   : command pushed at edge N into an idle bridge -> SETUP after N+1, ACCESS after N+2, done after N+3 (zero-wait).
// Backpress : cmd_ready drops when the command FIFO holds CMD_DEPTH entries; a PREADY stall holds the FIFO head.
//
// Ports:
//   PCLK, PRESETn                      clock, async active-low reset
//   transfer/cmd_ready                 command push handshake
//   write_read, addr_in, wdata_in,     command fields (1=write)
//   strb_in
//   rdata_out, transfer_done, error    completion report (done is a 1-cycle pulse)
//   PADDR..PSTRB                       registered APB request outputs, PSEL one-hot
//   PRDATA, PREADY, PSLVERR            per-slave APB responses
module apb_master_multi_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             transfer,
  output logic                             cmd_ready,
  input  logic                             write_read,
  input  logic [ADDR_WIDTH-1:0]            addr_in,
  input  logic [DATA_WIDTH-1:0]            wdata_in,
  input  logic [DATA_WIDTH/8-1:0]          strb_in,
  output logic [DATA_WIDTH-1:0]            rdata_out,
  output logic                             transfer_done,
  output logic                             error,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int SEL_W   = $clog2(NUM_SLAVES);
  localparam int PTR_W   = $clog2(CMD_DEPTH);
  localparam int CNT_W   = $clog2(CMD_DEPTH + 1);
  localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     strb;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  // ---------------- command FIFO ----------------
  cmd_t             r_mem [CMD_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push, w_pop, w_empty;
  cmd_t             w_head;
  logic [SEL_W-1:0] w_head_idx;

  // Ready looks only at the count, so a same-cycle pop never makes room early.
  assign cmd_ready  = (r_count < CNT_W'(CMD_DEPTH));
  assign w_push     = transfer && cmd_ready;
  assign w_empty    = (r_count == '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_idx = w_head.addr[ADDR_WIDTH-1 -: SEL_W];

  always_ff @(posedge PCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: addr_in, wr: write_read, wdata: wdata_in, strb: strb_in};
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(CMD_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(CMD_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // ---------------- APB engine ----------------
  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
  logic [NUM_SLAVES-1:0] r_psel, w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
  logic [STRB_W-1:0]     r_pstrb, w_pstrb_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic [TO_W-1:0]       r_to_cnt;

  logic                  w_sel_pready, w_sel_pslverr, w_timeout, w_complete;
  logic [DATA_WIDTH-1:0] w_sel_prdata;

  // Response mux keyed by the registered one-hot select, so other slaves are ignored.
  always_comb begin
    w_sel_pready  = 1'b0;
    w_sel_pslverr = 1'b0;
    w_sel_prdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_psel[i]) begin
        w_sel_pready  = PREADY[i];
        w_sel_pslverr = PSLVERR[i];
        w_sel_prdata  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Abort on the TIMEOUT_CYCLES-th consecutive ACCESS cycle with PREADY low.
  assign w_timeout  = (TIMEOUT_CYCLES > 0) && (r_state == S_ACCESS) && !w_sel_pready &&
                      (r_to_cnt == TO_W'(TO_LAST));
  assign w_complete = (r_state == S_ACCESS) && (w_sel_pready || w_timeout);
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || w_complete);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                                   r_to_cnt <= '0;
    else if (r_state == S_SETUP)                    r_to_cnt <= '0;
    else if (r_state == S_ACCESS && !w_sel_pready && !w_timeout)
                                                    r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_empty) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_complete) w_state_nxt = w_empty ? S_IDLE : S_SETUP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_paddr_nxt   = r_paddr;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_pwrite_nxt  = r_pwrite;
    w_pwdata_nxt  = r_pwdata;
    w_pstrb_nxt   = r_pstrb;
    w_rdata_nxt   = r_rdata;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    if (r_state == S_SETUP) w_penable_nxt = 1'b1;
    if (w_complete) begin
      w_done_nxt    = 1'b1;
      w_err_nxt     = w_timeout | w_sel_pslverr;
      if (!r_pwrite) w_rdata_nxt = w_timeout ? '0 : w_sel_prdata;
      w_psel_nxt    = '0;
      w_penable_nxt = 1'b0;
    end
    // Loading the next command overrides the drop to idle, giving gap-free back-to-back SETUPs.
    if (w_pop) begin
      w_paddr_nxt   = w_head.addr;
      w_pwrite_nxt  = w_head.wr;
      w_pwdata_nxt  = w_head.wr ? w_head.wdata : '0;
      w_pstrb_nxt   = w_head.wr ? w_head.strb  : '0;
      w_psel_nxt    = NUM_SLAVES'(1) << w_head_idx;
      w_penable_nxt = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_paddr   <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_rdata   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_paddr   <= w_paddr_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_pstrb   <= w_pstrb_nxt;
      r_rdata   <= w_rdata_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign PADDR         = r_paddr;
  assign PSEL          = r_psel;
  assign PENABLE       = r_penable;
  assign PWRITE        = r_pwrite;
  assign PWDATA        = r_pwdata;
  assign PSTRB         = r_pstrb;
  assign rdata_out     = r_rdata;
  assign transfer_done = r_done;
  assign error         = r_err;

endmodule
